// File: rtl/serial_io_controller_pkg.sv
// serial_ctrl_pkg: state encoding and shared constants for the
// serial I/O controller and the memory-stage address decode.
package serial_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_WAIT  = 3'd1,
        TX_PULSE = 3'd2,
        RX_WAIT  = 3'd3,
        RX_PULSE = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Load/store address the memory stage routes to this controller.
    localparam logic [31:0] SERIAL_ADDR = 32'hFFFF_FFF0;

    function automatic logic [31:0] zext8(input logic [7:0] b);
        return {24'h00_0000, b};
    endfunction

endpackage

// File: rtl/serial_io_controller_if.sv
// serial_io_controller_if: memory-stage request lines plus serial pins.
// master = controller side, slave = pipeline/port side.
interface serial_io_controller_if;

    logic        req_rd_in;
    logic        req_wr_in;
    logic [7:0]  wr_data_in;
    logic [31:0] rd_data_out;
    logic        stall_out;
    logic        timeout_out;
    logic [7:0]  serial_in;
    logic        serial_valid_in;
    logic        serial_ready_in;
    logic [7:0]  serial_out;
    logic        serial_rden_out;
    logic        serial_wren_out;

    modport master (
        input  req_rd_in,
        input  req_wr_in,
        input  wr_data_in,
        input  serial_in,
        input  serial_valid_in,
        input  serial_ready_in,
        output rd_data_out,
        output stall_out,
        output timeout_out,
        output serial_out,
        output serial_rden_out,
        output serial_wren_out
    );

    modport slave (
        output req_rd_in,
        output req_wr_in,
        output wr_data_in,
        output serial_in,
        output serial_valid_in,
        output serial_ready_in,
        input  rd_data_out,
        input  stall_out,
        input  timeout_out,
        input  serial_out,
        input  serial_rden_out,
        input  serial_wren_out
    );

endinterface

// File: rtl/serial_io_controller_timeout_counter.sv
// serial_timeout_counter: saturating wait-state counter; expire flags the
// last permitted wait cycle. TIMEOUT_CYCLES=0 never expires.
module serial_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TIMEOUT_W      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned LAST =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TIMEOUT_W-1:0] LAST_W = TIMEOUT_W'(LAST);
    localparam bit ACTIVE = (TIMEOUT_CYCLES > 0);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = ACTIVE && enable && (count == LAST_W);

endmodule

// File: rtl/serial_io_controller.sv
// serial_io_controller: turns memory-stage serial loads/stores into port
// handshakes. Optional macro SERIAL_RX_PREFETCH_EN adds a 1-byte RX buffer.
module serial_io_controller
    import serial_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TIMEOUT_W      = 16,
    parameter logic [31:0] ERR_WORD       = ERR_WORD_DEFAULT
) (
    input logic                   clk,
    input logic                   reset,
    serial_io_controller_if.master bus
);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  tx_q;
    logic [31:0] rd_q;
    logic        timeout_q;

    logic        req_any;
    logic        in_wait;
    logic        expire;
    logic        abort;
    logic        rx_cap;
    logic        err_load;
    logic        stall;
    logic        wren;
    logic        rden;

`ifdef SERIAL_RX_PREFETCH_EN
    logic [7:0]  buf_q;
    logic        buf_v;
    logic        buf_fill;
    logic        buf_take;
`endif

    assign req_any = bus.req_rd_in | bus.req_wr_in;
    assign in_wait = (state == TX_WAIT) || (state == RX_WAIT);

    serial_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (in_wait),
        .expire (expire)
    );

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        wren     = 1'b0;
        rden     = 1'b0;
        abort    = 1'b0;
        rx_cap   = 1'b0;
        err_load = 1'b0;
`ifdef SERIAL_RX_PREFETCH_EN
        buf_fill = 1'b0;
        buf_take = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                stall = req_any;
                // Write wins when both requests are raised together.
                if (bus.req_wr_in) begin
                    state_nx = TX_WAIT;
                end else if (bus.req_rd_in) begin
                    state_nx = RX_WAIT;
`ifdef SERIAL_RX_PREFETCH_EN
                    if (buf_v) begin
                        state_nx = DONE;
                        buf_take = 1'b1;
                    end
`endif
                end
`ifdef SERIAL_RX_PREFETCH_EN
                else if (!buf_v && bus.serial_valid_in) begin
                    buf_fill = 1'b1;
                    rden     = 1'b1;
                end
`endif
            end
            TX_WAIT: begin
                stall = 1'b1;
                if (bus.serial_ready_in) begin
                    state_nx = TX_PULSE;
                end else if (expire) begin
                    state_nx = DONE;
                    abort    = 1'b1;
                end
            end
            TX_PULSE: begin
                stall    = 1'b1;
                wren     = 1'b1;
                state_nx = DONE;
            end
            RX_WAIT: begin
                stall = 1'b1;
                if (bus.serial_valid_in) begin
                    state_nx = RX_PULSE;
                    rx_cap   = 1'b1;
                end else if (expire) begin
                    state_nx = DONE;
                    abort    = 1'b1;
                    err_load = 1'b1;
                end
            end
            RX_PULSE: begin
                stall    = 1'b1;
                rden     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx_q      <= '0;
            rd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nx;
            timeout_q <= abort;
            if ((state == IDLE) && bus.req_wr_in) begin
                tx_q <= bus.wr_data_in;
            end
            if (rx_cap) begin
                rd_q <= zext8(bus.serial_in);
            end else if (err_load) begin
                rd_q <= ERR_WORD;
            end
`ifdef SERIAL_RX_PREFETCH_EN
            else if (buf_take) begin
                rd_q <= zext8(buf_q);
            end
`endif
        end
    end

`ifdef SERIAL_RX_PREFETCH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
            buf_v <= 1'b0;
        end else if (buf_fill) begin
            buf_q <= bus.serial_in;
            buf_v <= 1'b1;
        end else if (buf_take) begin
            buf_v <= 1'b0;
        end
    end
`endif

    assign bus.stall_out       = stall;
    assign bus.serial_wren_out = wren;
    assign bus.serial_rden_out = rden;
    assign bus.serial_out      = tx_q;
    assign bus.rd_data_out     = rd_q;
    assign bus.timeout_out     = timeout_q;

endmodule

// File: tb/tb_serial_io_controller.sv
// tb_serial_io_controller: per-cycle vector table plus a transaction
// scoreboard for read data, timeout flag and stall length.
module tb_serial_io_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_io_controller_if bus0();
    serial_io_controller_if bus1();

    serial_io_controller #(
        .TIMEOUT_CYCLES (0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    serial_io_controller #(
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_W      (16),
        .ERR_WORD       (32'hFFFF_FFFF)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        bit          sel;
        bit          rd;
        bit          wr;
        logic [7:0]  wd;
        logic [7:0]  si;
        bit          v;
        bit          r;
        bit          st;
        bit          we;
        bit          re;
        bit          to;
        logic [7:0]  so;
        bit          push;
        logic [31:0] d;
        bit          tmo;
        int          stalls;
    } vec_t;

    typedef struct {
        bit          is_rd;
        logic [31:0] d;
        bit          tmo;
        int          stalls;
    } exp_t;

    typedef struct {
        logic        st;
        logic        we;
        logic        re;
        logic        to;
        logic [7:0]  so;
        logic [31:0] rd;
    } out_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   prev_stall[2];
    int   stall_run[2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input int sel, input int rd, input int wr, input int wd,
        input int si, input int v, input int r,
        input int st, input int we, input int re, input int to,
        input int so);
        vec_t x;
        x.sel = sel[0]; x.rd = rd[0]; x.wr = wr[0];
        x.wd = wd[7:0]; x.si = si[7:0];
        x.v = v[0]; x.r = r[0];
        x.st = st[0]; x.we = we[0]; x.re = re[0]; x.to = to[0];
        x.so = so[7:0];
        x.push = 1'b0; x.d = '0; x.tmo = 1'b0; x.stalls = 0;
        return x;
    endfunction

    function automatic vec_t txn(input vec_t x, input logic [31:0] d,
                                 input int tmo, input int stalls);
        x.push = 1'b1;
        x.d = d;
        x.tmo = tmo[0];
        x.stalls = stalls;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        if (x.sel) begin
            bus1.req_rd_in = x.rd; bus1.req_wr_in = x.wr;
            bus1.wr_data_in = x.wd; bus1.serial_in = x.si;
            bus1.serial_valid_in = x.v; bus1.serial_ready_in = x.r;
        end else begin
            bus0.req_rd_in = x.rd; bus0.req_wr_in = x.wr;
            bus0.wr_data_in = x.wd; bus0.serial_in = x.si;
            bus0.serial_valid_in = x.v; bus0.serial_ready_in = x.r;
        end
    endtask

    function automatic out_t sample(input bit sel);
        out_t o;
        if (sel) begin
            o.st = bus1.stall_out; o.we = bus1.serial_wren_out;
            o.re = bus1.serial_rden_out; o.to = bus1.timeout_out;
            o.so = bus1.serial_out; o.rd = bus1.rd_data_out;
        end else begin
            o.st = bus0.stall_out; o.we = bus0.serial_wren_out;
            o.re = bus0.serial_rden_out; o.to = bus0.timeout_out;
            o.so = bus0.serial_out; o.rd = bus0.rd_data_out;
        end
        return o;
    endfunction

    task automatic run_row(input int i, input vec_t x);
        out_t o;
        exp_t e;
        @(negedge clk);
        drive(x);
        if (x.push) begin
            e.is_rd = x.rd && !x.wr;
            e.d = x.d;
            e.tmo = x.tmo;
            e.stalls = x.stalls;
            sb.push_back(e);
        end
        #1;
        o = sample(x.sel);
        chk($sformatf("stall[%0d]", i), 32'(o.st), 32'(x.st));
        chk($sformatf("wren[%0d]", i), 32'(o.we), 32'(x.we));
        chk($sformatf("rden[%0d]", i), 32'(o.re), 32'(x.re));
        chk($sformatf("timeout[%0d]", i), 32'(o.to), 32'(x.to));
        chk($sformatf("serial_out[%0d]", i), 32'(o.so), 32'(x.so));
        if (o.st) stall_run[x.sel]++;
        if (prev_stall[x.sel] && !o.st) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty[%0d] actual=done required=pending", i);
            end else begin
                e = sb.pop_front();
                if (e.is_rd)
                    chk($sformatf("rd_data[%0d]", i), o.rd, e.d);
                chk($sformatf("done_timeout[%0d]", i), 32'(o.to), 32'(e.tmo));
                chk($sformatf("stall_len[%0d]", i),
                    32'(stall_run[x.sel]), 32'(e.stalls));
            end
            stall_run[x.sel] = 0;
        end
        prev_stall[x.sel] = o.st;
    endtask

    task automatic run_table();
        foreach (tbl[i]) run_row(i, tbl[i]);
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        out_t o;
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        for (int s = 0; s < 2; s++) begin
            o = sample(s[0]);
            chk($sformatf("rst_stall%0d", s), 32'(o.st), 0);
            chk($sformatf("rst_wren%0d", s), 32'(o.we), 0);
            chk($sformatf("rst_rden%0d", s), 32'(o.re), 0);
            chk($sformatf("rst_timeout%0d", s), 32'(o.to), 0);
            chk($sformatf("rst_serial_out%0d", s), 32'(o.so), 0);
            chk($sformatf("rst_rd_data%0d", s), o.rd, 0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Write 0x41, port ready; request held into DONE is ignored.
        tbl.push_back(txn(mk(0, 0, 1, 'h41, 0, 0, 1, 1, 0, 0, 0, 'h00), 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 'h41, 0, 0, 1, 1, 0, 0, 0, 'h41));
        tbl.push_back(mk(0, 0, 0, 'h41, 0, 0, 1, 1, 1, 0, 0, 'h41));
        tbl.push_back(mk(0, 0, 1, 'h41, 0, 0, 1, 0, 0, 0, 0, 'h41));
        // Both requests: write only, no rden despite valid.
        tbl.push_back(txn(mk(0, 1, 1, 'h33, 0, 1, 1, 1, 0, 0, 0, 'h41), 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 'h33, 0, 1, 1, 1, 0, 0, 0, 'h33));
        tbl.push_back(mk(0, 0, 0, 'h33, 0, 1, 1, 1, 1, 0, 0, 'h33));
        tbl.push_back(mk(0, 0, 0, 'h33, 0, 0, 0, 0, 0, 0, 0, 'h33));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h33));
        // Read with 10 empty wait cycles, then 0x5A.
        tbl.push_back(txn(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h33), 32'h5A, 0, 13));
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h33));
        tbl.push_back(mk(0, 0, 0, 0, 'h5A, 1, 0, 1, 0, 0, 0, 'h33));
        tbl.push_back(mk(0, 0, 0, 0, 'h5A, 1, 0, 1, 0, 1, 0, 'h33));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h33));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h33));
        // Timeout instance: read never served.
        tbl.push_back(txn(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 32'hFFFF_FFFF, 1, 9));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Valid rises on the expiry cycle: normal completion.
        tbl.push_back(txn(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 32'h3C, 0, 10));
        for (int k = 0; k < 7; k++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 'h3C, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 'h3C, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Write timeout: no wren, byte still latched.
        tbl.push_back(txn(mk(1, 0, 1, 'h55, 0, 0, 0, 1, 0, 0, 0, 0), 0, 1, 9));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h55));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h55));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h55));
        run_table();

        // Reset while waiting in TX_WAIT.
        @(negedge clk);
        bus0.req_wr_in = 1'b1;
        bus0.wr_data_in = 8'h77;
        bus0.serial_ready_in = 1'b0;
        @(negedge clk);
        bus0.req_wr_in = 1'b0;
        #1;
        chk("pre_rst_stall", 32'(bus0.stall_out), 1);
        #1 reset = 1'b1;
        #1;
        o = sample(1'b0);
        chk("mid_rst_stall", 32'(o.st), 0);
        chk("mid_rst_wren", 32'(o.we), 0);
        chk("mid_rst_rden", 32'(o.re), 0);
        chk("mid_rst_timeout", 32'(o.to), 0);
        chk("mid_rst_serial_out", 32'(o.so), 0);
        chk("mid_rst_rd_data", o.rd, 0);
        @(negedge clk);
        reset = 1'b0;
        bus0.serial_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("post_rst_wren[%0d]", k),
                32'(bus0.serial_wren_out), 0);
            chk($sformatf("post_rst_stall[%0d]", k),
                32'(bus0.stall_out), 0);
            @(negedge clk);
        end
        bus0.serial_ready_in = 1'b0;

`ifdef SERIAL_RX_PREFETCH_EN
        // Idle prefetch of 0x7E, then a 1-stall read from the buffer.
        tbl.push_back(mk(0, 0, 0, 0, 'h7E, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(txn(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 32'h7E, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
        // Without the buffer, an idle valid byte is left in the port.
        tbl.push_back(mk(0, 0, 0, 0, 'h7E, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
        run_table();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
